// File: rtl/key_encoder_pkg.sv
// Shared constants, FSM state type and priority-encode helper for the key encoder.
package key_encoder_pkg;

   localparam int NUM_KEYS = 7;
   localparam int CODE_W   = 3;
   localparam int CNT_W    = 16;
   localparam logic [CODE_W-1:0] CODE_NONE = 3'd7;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESSED = 1'b1
   } state_t;

   // Highest set bit wins; inverse of the one-hot decoder, all-zero -> CODE_NONE.
   function automatic logic [CODE_W-1:0] prio_enc(input logic [NUM_KEYS-1:0] v);
      prio_enc = CODE_NONE;
      for (int i = 0; i < NUM_KEYS; i++)
         if (v[i]) prio_enc = CODE_W'(i);
   endfunction

endpackage

// File: rtl/key_encoder_debounce.sv
// One request bit: 2-flop synchronizer, agreement counter and debounced state flop.
module key_debounce
   import key_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 12000
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_req,
   output logic o_state
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1, r_sync2, r_state;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_req;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_state) begin
            r_cnt <= '0;
         end else if (r_cnt == LIMIT) begin
            // this cycle is the DEBOUNCE_CYCLES-th consecutive disagreement
            r_state <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/key_encoder.sv
// Debounced 7-key priority encoder with VALID/ACK handshake and sticky OVERRUN.
// Optional MULTI flag enabled by defining KEY_ENCODER_MULTI_ERR_EN.
module key_encoder
   import key_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 12000
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NUM_KEYS-1:0] REQ,
   input  logic                ACK,
   output logic [CODE_W-1:0]   CODE,
   output logic                VALID,
   output logic                HELD,
   output logic                OVERRUN,
   output logic                MULTI
);

   logic [NUM_KEYS-1:0] w_deb;
   state_t              r_state, w_next;
   logic                w_latch, w_ack;
   logic [CODE_W-1:0]   r_code;
   logic                r_valid, r_overrun;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .CLK     (CLK),
         .RST     (RST),
         .i_req   (REQ[g]),
         .o_state (w_deb[g])
      );
   end

   always_ff @(posedge CLK) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_latch = 1'b0;
      case (r_state)
         IDLE: if (|w_deb) begin
            w_next  = PRESSED;
            w_latch = 1'b1;
         end
         PRESSED: if (w_deb == '0) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_ack = r_valid & ACK;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_code    <= CODE_NONE;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_latch) begin
         // a latch beats a coincident ACK; only an unacknowledged code counts as overrun
         r_code    <= prio_enc(w_deb);
         r_valid   <= 1'b1;
         r_overrun <= r_valid & ~ACK ? 1'b1 : (w_ack ? 1'b0 : r_overrun);
      end else if (w_ack) begin
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end
   end

`ifdef KEY_ENCODER_MULTI_ERR_EN
   logic r_multi;
   always_ff @(posedge CLK) begin
      if (RST)          r_multi <= 1'b0;
      else if (w_latch) r_multi <= (w_deb & (w_deb - 1'b1)) != '0;
   end
   assign MULTI = r_multi;
`else
   assign MULTI = 1'b0;
`endif

   assign CODE    = r_code;
   assign VALID   = r_valid;
   assign HELD    = (r_state == PRESSED);
   assign OVERRUN = r_overrun;

endmodule
